// File: rtl/ibus_sram_port.sv
// ibus_sram_port: request/response front end for the single-port ibus SRAM macro.
// Zero-fills the array after reset or on request, hides the macro's one-cycle read latency and
// buffers up to two read responses so a stalled consumer never loses data.
module ibus_sram_port #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_init_req,
  output logic          o_init_done,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  input  logic [DW-1:0] i_req_wmask,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_rdata,
  output logic          o_sram_me,
  output logic          o_sram_we,
  output logic [AW-1:0] o_sram_a,
  output logic [DW-1:0] o_sram_d,
  output logic [DW-1:0] o_sram_wem,
  input  logic [DW-1:0] i_sram_q
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e        r_state;
  logic [AW-1:0] r_ptr;
  logic          r_pend;
  logic [1:0]    r_cnt;
  logic          r_head;
  logic          r_tail;
  logic [DW-1:0] r_fifo [2];

  logic          w_run;
  logic [1:0]    w_occ;
  logic          w_acc;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_nonempty;

  // Credit, accept and response-buffer control; occupancy counts the in-flight read too.
  always_comb begin
    w_run           = (r_state == StRun);
    w_occ           = r_cnt + {1'b0, r_pend};
    o_req_ready     = w_run && (w_occ < 2'd2);
    w_acc           = i_req_valid && o_req_ready;
    o_init_done     = w_run;
    w_fifo_nonempty = (r_cnt != 2'd0);
    o_rsp_valid     = w_fifo_nonempty || r_pend;
    o_rsp_rdata     = w_fifo_nonempty ? r_fifo[r_head] : i_sram_q;
    w_pop           = w_fifo_nonempty && i_rsp_ready;
    // Macro data lands in the FIFO unless it leaves straight through the bypass path.
    w_push          = r_pend && !(!w_fifo_nonempty && i_rsp_ready);
  end

  // Macro drive: zero-fill sweep in INIT, pass-through of the accepted request in RUN.
  always_comb begin
    o_sram_me  = 1'b0;
    o_sram_we  = 1'b0;
    o_sram_a   = '0;
    o_sram_d   = '0;
    o_sram_wem = '0;
    if (i_rst) begin
      // Keep the macro idle while reset is held, even though the FSM already sits in INIT.
      o_sram_me = 1'b0;
    end else if (!w_run) begin
      o_sram_me  = 1'b1;
      o_sram_we  = 1'b1;
      o_sram_a   = r_ptr;
      o_sram_d   = '0;
      o_sram_wem = '1;
    end else begin
      o_sram_me  = w_acc;
      o_sram_we  = i_req_we;
      o_sram_a   = i_req_addr;
      o_sram_d   = i_req_wdata;
      o_sram_wem = i_req_wmask;
    end
  end

  // Init/run FSM with the fill address pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StInit;
      r_ptr   <= '0;
    end else begin
      unique case (r_state)
        StInit: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == '1) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          // Re-fill only when no read response could still be produced or waiting.
          if (i_init_req && !r_pend && (r_cnt == 2'd0)) begin
            r_state <= StInit;
            r_ptr   <= '0;
          end
        end
        default: begin
          r_state <= StInit;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // Read-pending flag and response FIFO pointers/occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend <= 1'b0;
      r_cnt  <= 2'd0;
      r_head <= 1'b0;
      r_tail <= 1'b0;
    end else begin
      r_pend <= w_acc && !i_req_we;
      r_cnt  <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_push) begin
        r_tail <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
    end
  end

  // Response FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_tail] <= i_sram_q;
    end
  end

endmodule

// File: tb/tb_ibus_sram_port.sv
// Directed bench for ibus_sram_port with a behavioural model of the SRAM macro.
module tb_ibus_sram_port;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_req;
  logic          init_done;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          sram_me;
  logic          sram_we;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_wem;
  logic [DW-1:0] sram_q;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ibus_sram_port #(.AW(AW), .DW(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_init_req  (init_req),
    .o_init_done (init_done),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_wmask (req_wmask),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_sram_me   (sram_me),
    .o_sram_we   (sram_we),
    .o_sram_a    (sram_a),
    .o_sram_d    (sram_d),
    .o_sram_wem  (sram_wem),
    .i_sram_q    (sram_q)
  );

  // SRAM macro model: masked write, registered read that holds until the next read.
  logic [DW-1:0] mem [128];
  always @(posedge clk) begin
    if (sram_me) begin
      if (sram_we) mem[sram_a] <= (mem[sram_a] & ~sram_wem) | (sram_d & sram_wem);
      else         sram_q <= mem[sram_a];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one full-word or masked write, assuming the port is ready.
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] m);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    #1;
    check_eq("wr_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Single read with the consumer ready; response expected the cycle after acceptance.
  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    #1;
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_eq(tag, rsp_rdata, exp);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] got [$];
    int k;
    int n;
    rst = 1'b1; init_req = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b0;

    // Reset values.
    @(negedge clk); @(negedge clk); #1;
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_me_we", {30'd0, sram_me, sram_we}, 32'd0);
    check_eq("rst_a", 32'(sram_a), 32'd0);
    check_eq("rst_d", sram_d, 32'd0);
    check_eq("rst_wem", sram_wem, 32'd0);

    // Zero-fill sweep after reset release: 128 cycles, addresses 0..127.
    @(negedge clk); rst = 1'b0; #1;
    for (int c = 0; c < 128; c++) begin
      check_eq("fill_addr", 32'(sram_a), 32'(c));
      check_eq("fill_ctl", {28'd0, sram_me, sram_we, init_done, req_ready}, 32'hC);
      check_eq("fill_d", sram_d, 32'd0);
      check_eq("fill_wem", sram_wem, 32'hFFFF_FFFF);
      @(negedge clk); #1;
    end
    check_eq("run_init_done", 32'(init_done), 32'd1);
    check_eq("run_req_ready", 32'(req_ready), 32'd1);

    // Write then read-after-write to the same address.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h05; req_wdata = 32'hDEAD_BEEF;
    req_wmask = 32'hFFFF_FFFF; #1;
    check_eq("wr_me_we", {30'd0, sram_me, sram_we}, 32'd3);
    check_eq("wr_addr", 32'(sram_a), 32'h05);
    check_eq("wr_d", sram_d, 32'hDEAD_BEEF);
    @(negedge clk); req_we = 1'b0; rsp_ready = 1'b1; #1;
    check_eq("rd_me_we", {30'd0, sram_me, sram_we}, 32'd2);
    check_eq("rd_no_early_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk); req_valid = 1'b0; #1;
    check_eq("rd_lat_valid", 32'(rsp_valid), 32'd1);
    check_eq("rd_data", rsp_rdata, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    check_eq("rd_done", 32'(rsp_valid), 32'd0);

    // Back-to-back reads with the consumer stalled: credit stops at two.
    for (int i = 0; i < 4; i++) write_word(7'(i), 32'h100 + 32'(i), 32'hFFFF_FFFF);
    rsp_ready = 1'b0; k = 0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 7'(k); #1;
      check_eq("bp_ready", 32'(req_ready), 32'(c < 2));
      if (c > 0) begin
        check_eq("bp_hold_valid", 32'(rsp_valid), 32'd1);
        check_eq("bp_hold_data", rsp_rdata, 32'h100);
      end
      if (req_ready) k++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      req_valid = (k < 4); req_addr = 7'(k); #1;
      if (rsp_valid) got.push_back(rsp_rdata);
      if (req_valid && req_ready) k++;
      @(negedge clk);
    end
    req_valid = 1'b0; #1;
    check_eq("bp_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++) check_eq("bp_order", got[i], 32'h100 + 32'(i));
    check_eq("bp_drained", 32'(rsp_valid), 32'd0);
    @(negedge clk);

    // Masked write merges only the low half.
    write_word(7'h10, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h10; req_wdata = 32'h1234_5678;
    req_wmask = 32'h0000_FFFF; #1;
    check_eq("mask_wem", sram_wem, 32'h0000_FFFF);
    check_eq("mask_d", sram_d, 32'h1234_5678);
    @(negedge clk); req_valid = 1'b0;
    read_check("mask_rd", 7'h10, 32'hAAAA_5678);

    // init_req while a read response is outstanding is ignored.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h05;
    @(negedge clk); req_valid = 1'b0; init_req = 1'b1; #1;
    check_eq("ign_pend_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk); init_req = 1'b0; #1;
    check_eq("ign_init_done", 32'(init_done), 32'd1);
    check_eq("ign_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("ign_rsp_data", rsp_rdata, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("ign_drained", 32'(rsp_valid), 32'd0);
    check_eq("ign_still_run", 32'(init_done), 32'd1);

    // init_req while idle: a 128-cycle fill, then previously written words read as zero.
    init_req = 1'b1;
    @(negedge clk); init_req = 1'b0; #1;
    n = 0;
    while (init_done == 1'b0 && n < 300) begin
      n++;
      @(negedge clk); #1;
    end
    check_eq("refill_len", 32'(n), 32'd128);
    @(negedge clk);
    read_check("refill_rd05", 7'h05, 32'd0);
    read_check("refill_rd10", 7'h10, 32'd0);

    // Reset with two responses buffered.
    write_word(7'h01, 32'h5555_0001, 32'hFFFF_FFFF);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h01;
    @(negedge clk); req_addr = 7'h02;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); #1;
    check_eq("rs_pre_valid", 32'(rsp_valid), 32'd1);
    check_eq("rs_pre_data", rsp_rdata, 32'h5555_0001);
    check_eq("rs_pre_ready", 32'(req_ready), 32'd0);
    rst = 1'b1; #1;
    check_eq("rs_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rs_me", 32'(sram_me), 32'd0);
    check_eq("rs_init_done", 32'(init_done), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check_eq("rs_fill_a0", 32'(sram_a), 32'd0);
    check_eq("rs_fill_ctl", {30'd0, sram_me, sram_we}, 32'd3);
    check_eq("rs_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;
    check_eq("rs_fill_a1", 32'(sram_a), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
